// File: rtl/sprite_engine.sv
// Multi-sprite hit-test engine: NSPR loadable SIZE x SIZE bitmaps with double-buffered
// positions, a 2-stage hit pipeline and a per-frame covered-pixel counter.
module sprite_engine #(
   parameter int NSPR = 4,
   parameter int SIZE = 32,
   parameter int CW   = 11,
   parameter int IDW  = 2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            frame_start,
   input  logic            wr_en,
   input  logic            wr_sel,
   input  logic [IDW-1:0]  wr_id,
   input  logic [4:0]      wr_row,
   input  logic [31:0]     wr_data,
   input  logic            pix_valid,
   input  logic [CW-1:0]   pix_x,
   input  logic [CW-1:0]   pix_y,
   output logic            hit_valid,
   output logic            hit,
   output logic [IDW-1:0]  hit_id,
   output logic [15:0]     frame_hits
);

   localparam int OW = $clog2(SIZE);
   localparam int SW = CW + 2;
   localparam logic signed [SW-1:0] HALF = SW'(SIZE / 2);
   localparam logic signed [SW-1:0] SPAN = SW'(SIZE - 1);
   localparam logic signed [SW-1:0] ZERO = '0;

   logic [SIZE-1:0] bmp_q [NSPR][SIZE];
   logic [SIZE-1:0] bmp_d [NSPR][SIZE];
   logic [CW-1:0]   sh_cx_q [NSPR], sh_cx_d [NSPR], sh_cy_q [NSPR], sh_cy_d [NSPR];
   logic [CW-1:0]   act_cx_q [NSPR], act_cx_d [NSPR], act_cy_q [NSPR], act_cy_d [NSPR];
   logic            sh_en_q [NSPR], sh_en_d [NSPR], act_en_q [NSPR], act_en_d [NSPR];

   logic            s1_valid_q, s1_valid_d;
   logic            s1_in_q [NSPR], s1_in_d [NSPR];
   logic [OW-1:0]   s1_row_q [NSPR], s1_row_d [NSPR];
   logic [OW-1:0]   s1_col_q [NSPR], s1_col_d [NSPR];

   logic            hit_valid_q, hit_valid_d, hit_q, hit_d;
   logic [IDW-1:0]  hit_id_q, hit_id_d;
   logic [15:0]     count_q, count_d, frame_hits_q, frame_hits_d;
   logic [15:0]     count_sum;

   // Configuration writes; the active copy takes the shadow including a same-cycle write
   always_comb begin
      bmp_d    = bmp_q;
      sh_cx_d  = sh_cx_q;
      sh_cy_d  = sh_cy_q;
      sh_en_d  = sh_en_q;
      act_cx_d = act_cx_q;
      act_cy_d = act_cy_q;
      act_en_d = act_en_q;
      if (wr_en && (32'(wr_id) < NSPR)) begin
         if (!wr_sel) begin
            if (32'(wr_row) < SIZE)
               bmp_d[wr_id][wr_row[OW-1:0]] = wr_data[SIZE-1:0];
         end else begin
            sh_cx_d[wr_id] = wr_data[CW-1:0];
            sh_cy_d[wr_id] = wr_data[11 +: CW];
            sh_en_d[wr_id] = wr_data[22];
         end
      end
      if (frame_start) begin
         act_cx_d = sh_cx_d;
         act_cy_d = sh_cy_d;
         act_en_d = sh_en_d;
      end
   end

   // Offsets are measured from the box corner in a widened signed domain, so no wrap occurs
   always_comb begin
      logic signed [SW-1:0] dx, dy;
      s1_valid_d = pix_valid;
      for (int s = 0; s < NSPR; s++) begin
         dx = $signed({2'b00, pix_x}) - ($signed({2'b00, act_cx_q[s]}) - HALF);
         dy = $signed({2'b00, pix_y}) - ($signed({2'b00, act_cy_q[s]}) - HALF);
         s1_in_d[s]  = act_en_q[s] && (dx >= ZERO) && (dx <= SPAN)
                                   && (dy >= ZERO) && (dy <= SPAN);
         s1_col_d[s] = dx[OW-1:0];
         s1_row_d[s] = dy[OW-1:0];
      end
   end

   // Bitmap lookup and priority encode; descending scan leaves the lowest index winning
   always_comb begin
      hit_valid_d = s1_valid_q;
      hit_d       = 1'b0;
      hit_id_d    = '0;
      for (int s = NSPR - 1; s >= 0; s--) begin
         if (s1_valid_q && s1_in_q[s] && bmp_q[s][s1_row_q[s]][s1_col_q[s]]) begin
            hit_d    = 1'b1;
            hit_id_d = IDW'(s);
         end
      end
   end

   always_comb begin
      count_sum    = (count_q == 16'hFFFF) ? 16'hFFFF
                                           : count_q + {15'b0, (hit_valid_q && hit_q)};
      count_d      = frame_start ? 16'h0000 : count_sum;
      frame_hits_d = frame_start ? count_sum : frame_hits_q;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int s = 0; s < NSPR; s++) begin
            for (int r = 0; r < SIZE; r++)
               bmp_q[s][r] <= '0;
            sh_cx_q[s]  <= '0;
            sh_cy_q[s]  <= '0;
            sh_en_q[s]  <= 1'b0;
            act_cx_q[s] <= '0;
            act_cy_q[s] <= '0;
            act_en_q[s] <= 1'b0;
            s1_in_q[s]  <= 1'b0;
            s1_row_q[s] <= '0;
            s1_col_q[s] <= '0;
         end
         s1_valid_q   <= 1'b0;
         hit_valid_q  <= 1'b0;
         hit_q        <= 1'b0;
         hit_id_q     <= '0;
         count_q      <= '0;
         frame_hits_q <= '0;
      end else begin
         bmp_q        <= bmp_d;
         sh_cx_q      <= sh_cx_d;
         sh_cy_q      <= sh_cy_d;
         sh_en_q      <= sh_en_d;
         act_cx_q     <= act_cx_d;
         act_cy_q     <= act_cy_d;
         act_en_q     <= act_en_d;
         s1_valid_q   <= s1_valid_d;
         s1_in_q      <= s1_in_d;
         s1_row_q     <= s1_row_d;
         s1_col_q     <= s1_col_d;
         hit_valid_q  <= hit_valid_d;
         hit_q        <= hit_d;
         hit_id_q     <= hit_id_d;
         count_q      <= count_d;
         frame_hits_q <= frame_hits_d;
      end
   end

   assign hit_valid  = hit_valid_q;
   assign hit        = hit_q;
   assign hit_id     = hit_id_q;
   assign frame_hits = frame_hits_q;

endmodule

// File: tb/tb_sprite_engine.sv
// Self-checking bench for sprite_engine: directed scenarios plus randomized traffic
// compared every cycle against a coordinate-arithmetic reference model.
module tb_sprite_engine;

   localparam int NSPR = 4;
   localparam int SIZE = 32;
   localparam int CW   = 11;
   localparam int IDW  = 2;
   localparam int H    = SIZE / 2;

   logic           clk = 1'b0;
   logic           rst;
   logic           frame_start, wr_en, wr_sel;
   logic [IDW-1:0] wr_id;
   logic [4:0]     wr_row;
   logic [31:0]    wr_data;
   logic           pix_valid;
   logic [CW-1:0]  pix_x, pix_y;
   logic           hit_valid, hit;
   logic [IDW-1:0] hit_id;
   logic [15:0]    frame_hits;

   int vectors = 0;
   int miscompares = 0;

   logic [31:0] m_bmp [NSPR][SIZE];
   int  m_sh_cx [NSPR], m_sh_cy [NSPR], m_ac_cx [NSPR], m_ac_cy [NSPR];
   bit  m_sh_en [NSPR], m_ac_en [NSPR];
   bit  m1_valid;
   bit  m1_in [NSPR];
   int  m1_row [NSPR], m1_col [NSPR];
   bit  mo_valid, mo_hit;
   int  mo_id, m_count, m_fh;

   sprite_engine #(.NSPR(NSPR), .SIZE(SIZE), .CW(CW), .IDW(IDW)) dut (
      .clk(clk), .rst(rst), .frame_start(frame_start),
      .wr_en(wr_en), .wr_sel(wr_sel), .wr_id(wr_id), .wr_row(wr_row), .wr_data(wr_data),
      .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y),
      .hit_valid(hit_valid), .hit(hit), .hit_id(hit_id), .frame_hits(frame_hits)
   );

   always #5 clk = ~clk;

   task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int s = 0; s < NSPR; s++) begin
         for (int r = 0; r < SIZE; r++) m_bmp[s][r] = '0;
         m_sh_cx[s] = 0; m_sh_cy[s] = 0; m_sh_en[s] = 0;
         m_ac_cx[s] = 0; m_ac_cy[s] = 0; m_ac_en[s] = 0;
         m1_in[s] = 0; m1_row[s] = 0; m1_col[s] = 0;
      end
      m1_valid = 0; mo_valid = 0; mo_hit = 0; mo_id = 0; m_count = 0; m_fh = 0;
   endtask

   // Advance the model by one clock using the current inputs, clock the DUT, compare outputs
   task automatic apply_stimulus();
      bit nv, nh;
      int nid, inc, px, py, lx, ly;
      nv = m1_valid; nh = 0; nid = 0;
      if (m1_valid)
         for (int s = 0; s < NSPR; s++)
            if (!nh && m1_in[s] && m_bmp[s][m1_row[s]][m1_col[s]]) begin nh = 1; nid = s; end
      inc = (mo_valid && mo_hit) ? 1 : 0;
      if (frame_start) begin
         m_fh = (m_count + inc > 65535) ? 65535 : m_count + inc;
         m_count = 0;
      end else
         m_count = (m_count + inc > 65535) ? 65535 : m_count + inc;
      px = pix_x; py = pix_y;
      m1_valid = pix_valid;
      for (int s = 0; s < NSPR; s++) begin
         lx = m_ac_cx[s] - H; ly = m_ac_cy[s] - H;
         m1_in[s] = m_ac_en[s] && px >= lx && px <= lx + SIZE - 1 && py >= ly && py <= ly + SIZE - 1;
         m1_col[s] = m1_in[s] ? px - lx : 0;
         m1_row[s] = m1_in[s] ? py - ly : 0;
      end
      if (wr_en && int'(wr_id) < NSPR) begin
         if (!wr_sel) begin
            if (int'(wr_row) < SIZE) m_bmp[wr_id][wr_row] = wr_data;
         end else begin
            m_sh_cx[wr_id] = int'(wr_data[10:0]);
            m_sh_cy[wr_id] = int'(wr_data[21:11]);
            m_sh_en[wr_id] = wr_data[22];
         end
      end
      if (frame_start)
         for (int s = 0; s < NSPR; s++) begin
            m_ac_cx[s] = m_sh_cx[s]; m_ac_cy[s] = m_sh_cy[s]; m_ac_en[s] = m_sh_en[s];
         end
      mo_valid = nv; mo_hit = nh; mo_id = nid;
      @(posedge clk);
      #1;
      check_output("hit_valid", hit_valid, mo_valid);
      check_output("hit", hit, mo_hit);
      check_output("hit_id", hit_id, mo_id);
      check_output("frame_hits", frame_hits, m_fh);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) apply_stimulus();
   endtask

   task automatic write_row(input int id, input int row, input logic [31:0] data);
      wr_en = 1; wr_sel = 0; wr_id = IDW'(id); wr_row = 5'(row); wr_data = data;
      apply_stimulus();
      wr_en = 0;
   endtask

   task automatic write_pos(input int id, input int cx, input int cy, input bit en, input bit fs);
      logic [10:0] cx_b, cy_b;
      cx_b = 11'(cx); cy_b = 11'(cy);
      wr_en = 1; wr_sel = 1; wr_id = IDW'(id); wr_data = {9'b0, en, cy_b, cx_b};
      frame_start = fs;
      apply_stimulus();
      wr_en = 0; frame_start = 0;
   endtask

   task automatic fill(input int id);
      for (int r = 0; r < SIZE; r++) write_row(id, r, 32'hFFFF_FFFF);
   endtask

   task automatic frame();
      frame_start = 1;
      apply_stimulus();
      frame_start = 0;
   endtask

   // Present one pixel and let it reach the outputs
   task automatic probe(input int x, input int y);
      pix_valid = 1; pix_x = CW'(x); pix_y = CW'(y);
      apply_stimulus();
      pix_valid = 0;
      apply_stimulus();
   endtask

   initial begin
      rst = 0; frame_start = 0; wr_en = 0; wr_sel = 0; wr_id = '0; wr_row = '0;
      wr_data = '0; pix_valid = 0; pix_x = '0; pix_y = '0;
      model_reset();
      #2;
      check_output("rst_hit_valid", hit_valid, 0);
      check_output("rst_hit", hit, 0);
      check_output("rst_frame_hits", frame_hits, 0);
      #10 rst = 1;

      probe(100, 100);
      check_output("t1_valid", hit_valid, 1);
      check_output("t1_hit", hit, 0);
      check_output("t1_id", hit_id, 0);

      fill(1);
      write_pos(1, 200, 150, 1, 0);
      frame();
      probe(184, 134);
      check_output("t2_lo_hit", hit, 1);
      check_output("t2_lo_id", hit_id, 1);
      probe(215, 165);
      check_output("t2_hi_hit", hit, 1);
      check_output("t2_hi_id", hit_id, 1);
      probe(183, 134);
      check_output("t2_left_miss", hit, 0);
      probe(216, 165);
      check_output("t2_right_miss", hit, 0);

      fill(0);
      fill(2);
      write_pos(0, 50, 50, 1, 0);
      write_pos(2, 50, 50, 1, 0);
      frame();
      probe(50, 50);
      check_output("t3_prio_id0", hit_id, 0);
      check_output("t3_prio_hit", hit, 1);
      write_pos(0, 50, 50, 0, 0);
      frame();
      probe(50, 50);
      check_output("t3_prio_id2", hit_id, 2);

      write_pos(0, 5, 5, 1, 1);
      probe(2040, 2040);
      check_output("t4_nowrap", hit, 0);
      probe(0, 0);
      check_output("t4_clip_hit", hit, 1);
      check_output("t4_clip_id", hit_id, 0);

      write_pos(0, 300, 300, 1, 0);
      probe(300, 300);
      check_output("t5_shadow_only", hit, 0);
      probe(5, 5);
      check_output("t5_old_pos", hit, 1);
      write_pos(0, 300, 300, 1, 1);
      probe(300, 300);
      check_output("t5_new_pos", hit, 1);

      frame();
      pix_valid = 1; pix_x = 11'd300; pix_y = 11'd300;
      idle(10);
      pix_valid = 0;
      idle(2);
      frame();
      check_output("t6_frame_hits", frame_hits, 10);

      pix_valid = 1;
      idle(3);
      rst = 0;
      model_reset();
      #2;
      check_output("t6_rst_valid", hit_valid, 0);
      check_output("t6_rst_frame_hits", frame_hits, 0);
      pix_valid = 0;
      #5 rst = 1;
      probe(300, 300);
      check_output("t6_cfg_cleared", hit, 0);

      for (int i = 0; i < 800; i++) begin
         pix_valid = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 9) == 0) begin
            pix_x = CW'($urandom_range(2000, 2047)); pix_y = CW'($urandom_range(2000, 2047));
         end else begin
            pix_x = CW'($urandom_range(0, 90)); pix_y = CW'($urandom_range(0, 90));
         end
         wr_en = ($urandom_range(0, 2) == 0);
         wr_sel = ($urandom_range(0, 3) == 0);
         wr_id = IDW'($urandom_range(0, NSPR - 1));
         wr_row = 5'($urandom_range(0, 31));
         if (wr_sel) begin
            if ($urandom_range(0, 7) == 0)
               wr_data = {9'b0, 1'b1, 11'($urandom_range(2030, 2047)), 11'($urandom_range(2030, 2047))};
            else
               wr_data = {9'b0, 1'($urandom_range(0, 4) != 0), 11'($urandom_range(0, 80)),
                          11'($urandom_range(0, 80))};
         end else
            wr_data = $urandom;
         frame_start = ($urandom_range(0, 40) == 0);
         apply_stimulus();
      end
      wr_en = 0; frame_start = 0; pix_valid = 0;
      idle(2);
      frame();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
